// File: rtl/fifo_drain_serializer.sv
// Pops FIFO words and streams them LSB-first as narrow beats with burst framing.
// Optional DRAIN_WORD_COUNT_EN adds a free-running completed-word counter.
module fifo_drain_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int BURST_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drain_en,
    input  logic [DATA_WIDTH-1:0] fifo_front,
    input  logic                  fifo_empty,
    output logic                  fifo_dequeue,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
`ifdef DRAIN_WORD_COUNT_EN
    ,
    output logic [31:0]           words_sent
`endif
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [BW-1:0] BEAT_LAST  = BW'(BEATS - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [CW-1:0]         burst_q, burst_d;

    logic hs;
    logic fin;
    logic done;
    logic load;

    assign hs   = (state_q == SEND) & out_ready;
    assign fin  = (beat_q == BEAT_LAST);
    assign done = hs & fin;
    // A new word may replace the current one on its final handshake.
    assign load = rst_n & drain_en & ~fifo_empty &
                  ((state_q == IDLE) | done);

    assign fifo_dequeue = load;
    assign out_valid    = (state_q == SEND);
    assign busy         = (state_q != IDLE);
    assign out_data     = shift_q[OUT_WIDTH-1:0];
    assign out_last     = out_valid & fin &
                          ((burst_q == BURST_LAST) | fifo_empty | ~drain_en);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        if (load) begin
            state_d = SEND;
            shift_d = fifo_front;
            beat_d  = '0;
        end else if (hs) begin
            shift_d = shift_q >> OUT_WIDTH;
            if (fin) begin
                state_d = IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        if (done) begin
            burst_d = out_last ? '0 : burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            beat_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

`ifdef DRAIN_WORD_COUNT_EN
    logic [31:0] words_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_q <= '0;
        end else if (done) begin
            words_q <= words_q + 32'd1;
        end
    end

    assign words_sent = words_q;
`endif

endmodule
